// File: rtl/sa_feeder_pkg.sv
// Shared types for the systolic-array feature feeder: FSM state encoding and lane feature type.
package sa_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FEAT_W = 8;

    typedef logic signed [FEAT_W-1:0] feat_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register for one feature lane; DEPTH sets that lane's skew plus output register.
module skew_delay_line
    import sa_feeder_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic signed [WIDTH-1:0] col_data,
    output logic signed [WIDTH-1:0] skew_data
);

    logic signed [WIDTH-1:0] pipe_p [0:DEPTH-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_p[i] <= '0;
            end
        end else begin
            pipe_p[0] <= col_data;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_p[i] <= pipe_p[i-1];
            end
        end
    end

    assign skew_data = pipe_p[DEPTH-1];

endmodule

// File: rtl/feature_skew_feeder.sv
// Feeds skewed feature columns into systolic_array for one pass; row r lags row 0 by r cycles.
module feature_skew_feeder
    import sa_feeder_pkg::*;
#(
    parameter int N_ROWS_ARRAY = 4,
    parameter int I_WIDTH      = 8,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [LEN_WIDTH-1:0]             num_vec_i,
    input  logic                             vec_valid_i,
    output logic                             vec_ready_o,
    input  logic [N_ROWS_ARRAY*I_WIDTH-1:0]  vec_data_i,
    output logic signed [I_WIDTH-1:0]        in_feature_o [0:N_ROWS_ARRAY-1],
    output logic                             start_op_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             underflow_o
);

    localparam int CNT_W = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N_ROWS_ARRAY - 1);

    state_t                   state;
    logic [LEN_WIDTH-1:0]     remaining;
    logic [CNT_W-1:0]         drain_cnt;
    logic                     accept;
    logic signed [I_WIDTH-1:0] col_p0 [0:N_ROWS_ARRAY-1];

    assign vec_ready_o = (state == RUN);
    assign accept      = vec_valid_i && vec_ready_o;

    // Stage p0: column entering the skew lines; bubbles and drain cycles inject zeros
    always_comb begin
        for (int r = 0; r < N_ROWS_ARRAY; r++) begin
            col_p0[r] = '0;
            if (accept) begin
                col_p0[r] = vec_data_i[r*I_WIDTH +: I_WIDTH];
            end
        end
    end

    for (genvar r = 0; r < N_ROWS_ARRAY; r++) begin : g_row
        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (I_WIDTH)
        ) u_skew (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .col_data  (col_p0[r]),
            .skew_data (in_feature_o[r])
        );
    end

    // start_op_o tracks columns one cycle behind the FSM; it drops as the last drain column lands
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            remaining   <= '0;
            drain_cnt   <= '0;
            start_op_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            start_op_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (num_vec_i != '0) begin
                            remaining   <= num_vec_i;
                            underflow_o <= 1'b0;
                            busy_o      <= 1'b1;
                            state       <= RUN;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    start_op_o <= 1'b1;
                    if (accept) begin
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end else begin
                        underflow_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        start_op_o <= 1'b1;
                        drain_cnt  <= drain_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_skew_feeder.sv
// Directed bench for feature_skew_feeder: per-cycle stimulus and hand-computed expectation tables.
module tb_feature_skew_feeder;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                start_i;
    logic [7:0]          num_vec_i;
    logic                vec_valid_i;
    logic                vec_ready_o;
    logic [31:0]         vec_data_i;
    logic signed [7:0]   in_feature_o [0:3];
    logic                start_op_o;
    logic                busy_o;
    logic                done_o;
    logic                underflow_o;
    logic [31:0]         lanes;

    int n_checks = 0;
    int n_pass   = 0;

    logic        st_tab  [0:15];
    logic [7:0]  num_tab [0:15];
    logic        vv_tab  [0:15];
    logic [31:0] dat_tab [0:15];
    logic        rst_tab [0:15];
    logic [3:0]  flg_tab [0:15];
    logic [31:0] ln_tab  [0:15];
    int          uf_tab  [0:15];

    feature_skew_feeder #(
        .N_ROWS_ARRAY (4),
        .I_WIDTH      (8),
        .LEN_WIDTH    (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .num_vec_i    (num_vec_i),
        .vec_valid_i  (vec_valid_i),
        .vec_ready_o  (vec_ready_o),
        .vec_data_i   (vec_data_i),
        .in_feature_o (in_feature_o),
        .start_op_o   (start_op_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    assign lanes = {in_feature_o[3], in_feature_o[2], in_feature_o[1], in_feature_o[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tab();
        for (int k = 0; k < 16; k++) begin
            st_tab[k]  = 1'b0;
            num_tab[k] = 8'd0;
            vv_tab[k]  = 1'b0;
            dat_tab[k] = 32'd0;
            rst_tab[k] = 1'b0;
            flg_tab[k] = 4'b0000;
            ln_tab[k]  = 32'd0;
            uf_tab[k]  = -1;
        end
    endtask

    // flags are {vec_ready_o, busy_o, start_op_o, done_o}; cycle 0 is the start_i cycle
    task automatic run_tab(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            start_i     = st_tab[k];
            num_vec_i   = num_tab[k];
            vec_valid_i = vv_tab[k];
            vec_data_i  = dat_tab[k];
            rst_i       = rst_tab[k];
            @(negedge clk_i);
            if (k >= 1) begin
                check($sformatf("%s c%0d flags", name, k),
                      {28'd0, vec_ready_o, busy_o, start_op_o, done_o}, {28'd0, flg_tab[k]});
                check($sformatf("%s c%0d lanes", name, k), lanes, ln_tab[k]);
                if (uf_tab[k] >= 0) begin
                    check($sformatf("%s c%0d underflow", name, k), {31'd0, underflow_o}, uf_tab[k]);
                end
            end
            @(posedge clk_i);
            #1;
        end
        start_i     = 1'b0;
        num_vec_i   = 8'd0;
        vec_valid_i = 1'b0;
        vec_data_i  = 32'd0;
        rst_i       = 1'b0;
    endtask

    // Clean three-vector pass: accepts at 1..3, start_op 2..7, done at 8
    task automatic load_t1();
        clear_tab();
        st_tab[0] = 1'b1; num_tab[0] = 8'd3;
        vv_tab[1] = 1'b1; dat_tab[1] = 32'h04030201;
        vv_tab[2] = 1'b1; dat_tab[2] = 32'h08070605;
        vv_tab[3] = 1'b1; dat_tab[3] = 32'h0C0B0A09;
        flg_tab[1] = 4'b1100; ln_tab[1] = 32'h00000000;
        flg_tab[2] = 4'b1110; ln_tab[2] = 32'h00000001;
        flg_tab[3] = 4'b1110; ln_tab[3] = 32'h00000205;
        flg_tab[4] = 4'b0110; ln_tab[4] = 32'h00030609;
        flg_tab[5] = 4'b0110; ln_tab[5] = 32'h04070A00;
        flg_tab[6] = 4'b0110; ln_tab[6] = 32'h080B0000;
        flg_tab[7] = 4'b0110; ln_tab[7] = 32'h0C000000;
        flg_tab[8] = 4'b0001; ln_tab[8] = 32'h00000000;
        for (int k = 1; k <= 8; k++) uf_tab[k] = 0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; num_vec_i = 8'd0;
        vec_valid_i = 1'b0; vec_data_i = 32'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset flags", {28'd0, vec_ready_o, busy_o, start_op_o, done_o}, 32'd0);
        check("reset lanes", lanes, 32'd0);
        check("reset underflow", {31'd0, underflow_o}, 32'd0);
        @(posedge clk_i);
        #1;

        clear_tab();
        for (int k = 1; k <= 5; k++) uf_tab[k] = 0;
        run_tab("idle", 6);

        // Bubble at cycle 2: zero column in that slot, pass stretches by one
        clear_tab();
        st_tab[0] = 1'b1; num_tab[0] = 8'd3;
        vv_tab[1] = 1'b1; dat_tab[1] = 32'h04030201;
        vv_tab[3] = 1'b1; dat_tab[3] = 32'h08070605;
        vv_tab[4] = 1'b1; dat_tab[4] = 32'h0C0B0A09;
        flg_tab[1] = 4'b1100; ln_tab[1] = 32'h00000000;
        flg_tab[2] = 4'b1110; ln_tab[2] = 32'h00000001;
        flg_tab[3] = 4'b1110; ln_tab[3] = 32'h00000200;
        flg_tab[4] = 4'b1110; ln_tab[4] = 32'h00030005;
        flg_tab[5] = 4'b0110; ln_tab[5] = 32'h04000609;
        flg_tab[6] = 4'b0110; ln_tab[6] = 32'h00070A00;
        flg_tab[7] = 4'b0110; ln_tab[7] = 32'h080B0000;
        flg_tab[8] = 4'b0110; ln_tab[8] = 32'h0C000000;
        flg_tab[9] = 4'b0001; ln_tab[9] = 32'h00000000;
        uf_tab[1] = 0; uf_tab[2] = 0;
        for (int k = 3; k <= 9; k++) uf_tab[k] = 1;
        run_tab("bubble", 10);

        load_t1();
        run_tab("clean", 9);

        clear_tab();
        st_tab[0] = 1'b1; num_tab[0] = 8'd0;
        flg_tab[1] = 4'b0001;
        flg_tab[2] = 4'b0000;
        run_tab("zero_len", 3);

        // Reset asserted during cycle 3 of a five-vector pass
        clear_tab();
        st_tab[0] = 1'b1; num_tab[0] = 8'd5;
        vv_tab[1] = 1'b1; dat_tab[1] = 32'h04030201;
        vv_tab[2] = 1'b1; dat_tab[2] = 32'h08070605;
        vv_tab[3] = 1'b1; dat_tab[3] = 32'h0C0B0A09;
        rst_tab[3] = 1'b1;
        flg_tab[1] = 4'b1100; ln_tab[1] = 32'h00000000;
        flg_tab[2] = 4'b1110; ln_tab[2] = 32'h00000001;
        flg_tab[3] = 4'b1110; ln_tab[3] = 32'h00000205;
        for (int k = 1; k <= 5; k++) uf_tab[k] = 0;
        run_tab("mid_reset", 6);

        load_t1();
        run_tab("after_reset", 9);

        // Ignored start during RUN, then back-to-back start in the done cycle
        load_t1();
        st_tab[2] = 1'b1; num_tab[2] = 8'd7;
        st_tab[8] = 1'b1; num_tab[8] = 8'd1;
        vv_tab[9] = 1'b1; dat_tab[9] = 32'h807FC32A;
        flg_tab[9]  = 4'b1100; ln_tab[9]  = 32'h00000000;
        flg_tab[10] = 4'b0110; ln_tab[10] = 32'h0000002A;
        flg_tab[11] = 4'b0110; ln_tab[11] = 32'h0000C300;
        flg_tab[12] = 4'b0110; ln_tab[12] = 32'h007F0000;
        flg_tab[13] = 4'b0110; ln_tab[13] = 32'h80000000;
        flg_tab[14] = 4'b0001; ln_tab[14] = 32'h00000000;
        for (int k = 9; k <= 14; k++) uf_tab[k] = 0;
        run_tab("b2b", 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/feature_skew_feeder.md
Name: feature_skew_feeder

Overview:
- Upstream stage of systolic_array. It takes one column vector of N_ROWS_ARRAY input features per cycle from the feature buffer over a valid/ready handshake.
- It applies the diagonal skew the array needs: row r is delayed r cycles relative to row 0.
- It drives in_feature_i and start_op_i of systolic_array for one pass of num_vec_i vectors, then zero-fills until the skew pipeline is empty and signals done.

Parameters:
- N_ROWS_ARRAY, 4, array rows = number of feature lanes and maximum skew depth.
- I_WIDTH, 8, signed feature width.
- LEN_WIDTH, 8, width of the pass-length counter.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse; starts a pass; sampled only in IDLE.
- num_vec_i  in  LEN_WIDTH  vectors in the pass; sampled with start_i.
- vec_valid_i  in  1  upstream vector valid.
- vec_ready_o  out  1  feeder accepts vector this cycle.
- vec_data_i  in  N_ROWS_ARRAY*I_WIDTH  packed vector; row r at [r*I_WIDTH +: I_WIDTH].
- in_feature_o  out  [0:N_ROWS_ARRAY-1] x I_WIDTH signed  skewed features to systolic_array in_feature_i.
- start_op_o  out  1  to systolic_array start_op_i.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at end of pass.
- underflow_o  out  1  sticky; a bubble was injected during the pass.

Behaviour:
- Reset (rst_i=1 at a clock edge), including mid-pass:
  - State goes to IDLE; counters clear.
  - All delay registers and every in_feature_o lane go to 0.
  - start_op_o, busy_o, done_o, underflow_o and vec_ready_o go to 0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start_i=1 with num_vec_i>0: latch remaining=num_vec_i, clear underflow_o, go to RUN.
  - start_i=1 with num_vec_i=0: done_o=1 next cycle; stay IDLE; start_op_o stays 0.
- RUN:
  - vec_ready_o=1 combinationally; it is 0 in all other states.
  - Handshake: a vector is accepted in a cycle where vec_valid_i=1 and vec_ready_o=1.
  - Each accepted vector decrements remaining. When remaining reaches 0 on an accept, go to DRAIN.
  - If vec_valid_i=0, a zero column enters the skew pipeline. The array has no stall, so the pass cannot pause. remaining is unchanged and underflow_o is set (sticky until the next accepted start_i or reset).
- DRAIN:
  - Zero columns are pushed for N_ROWS_ARRAY cycles.
  - On leaving DRAIN, done_o pulses for exactly one cycle, coinciding with the return to IDLE.
- start_i outside IDLE is ignored; num_vec_i is not resampled.
- Skew and latency: element r of a vector accepted (or bubble injected) at cycle t appears on in_feature_o[r] at cycle t+1+r.
- All outputs except vec_ready_o are registered.
- start_op_o:
  - Rises in the cycle the first vector's row-0 element appears on in_feature_o[0].
  - Stays 1 through the cycle the last vector's row N_ROWS_ARRAY-1 element appears on in_feature_o[N_ROWS_ARRAY-1].
  - Drops to 0 in the same cycle done_o pulses.
  - With last accept at cycle L: start_op_o is 1 up to L+N_ROWS_ARRAY, and done_o is at L+N_ROWS_ARRAY+1.
- Data is passed through unmodified; there is no arithmetic.
- Lanes carry 0 whenever not carrying pass data, including during IDLE.
- Back-to-back passes: start_i is accepted in the cycle done_o is high. The earliest new accept is the following cycle.

Decomposition:
- Package sa_feeder_pkg:
  - state enum typedef (IDLE/RUN/DRAIN).
  - feat_t: signed [I_WIDTH-1:0].
- Sub-module skew_delay_line (params DEPTH, WIDTH):
  - DEPTH-stage shift register, synchronous reset to 0.
  - Instantiated per row with DEPTH=r+1 to form the triangular skew.
- FSM and counters live in the top module.

Test Plan:
- Reset -> all outputs 0; vec_ready_o=0; in_feature_o all 0 for 5 cycles after reset release with no start_i.
- start_i at cycle 0 with num_vec_i=3; vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} valid, accepted at cycles 1, 2, 3 ->
  - in_feature_o[0]=1,5,9 at cycles 2-4.
  - in_feature_o[3]=4,8,12 at cycles 5-7.
  - start_op_o high cycles 2-7; done_o at cycle 8; underflow_o=0.
- Same pass with vec_valid_i=0 at cycle 2 ->
  - Zero column at that slot; vectors 2 and 3 accepted at cycles 3 and 4.
  - start_op_o high cycles 2-8; done_o at 9; underflow_o=1 until the next start_i.
- start_i with num_vec_i=0 -> done_o at cycle 1 only; start_op_o and busy_o stay 0.
- rst_i=1 at cycle 3 of a 5-vector pass -> next cycle: IDLE, all lanes 0, start_op_o=0, no done_o; a subsequent start_i runs a normal pass.
- start_i pulsed during RUN -> ignored, pass length unchanged. start_i in the done_o cycle -> second pass begins; first accept on the next cycle.
